// File: rtl/rca_seq_pkg.sv
// Shared types and sizing helpers for the sequential ripple-carry adder front end.
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

  // A single-slice build still needs a 1-bit index register.
  function automatic int calc_idx_w(input int width);
    int n;
    n = width / SLICE_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rca_slice4.sv
// Combinational 4-bit ripple-carry adder slice built from full-adder cells.
module rca_slice4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       ci,
  output logic [3:0] s4,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s4[i]  = a4[i] ^ b4[i] ^ c[i];
    assign c[i+1] = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/rca_seq_add_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit slice over WIDTH/4 cycles, LSB nibble first.
// Optional macro RCA_SEQ_OVF_FLAG_EN adds a signed-overflow output ovf.
module rca_seq_add_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef RCA_SEQ_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = calc_nslice(WIDTH);
  localparam int IDX_W  = calc_idx_w(WIDTH);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ADD  = ADD;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $fatal(1, "rca_seq_add_ctrl: WIDTH=%0d must be a multiple of 4 and >= 4", WIDTH);
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and a producer must hold its data until then.
  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;

  logic [IDX_W+1:0] base;
  logic [3:0]       a4;
  logic [3:0]       b4;
  logic [3:0]       s4;
  logic             co;

  assign base = {idx, 2'b00};
  assign a4   = a_q[base +: SLICE_W];
  assign b4   = b_q[base +: SLICE_W];

  rca_slice4 u_slice (
    .a4 (a4),
    .b4 (b4),
    .ci (carry_q),
    .s4 (s4),
    .co (co)
  );

`ifdef RCA_SEQ_OVF_FLAG_EN
  logic ovf_q;
  logic msb_cin;

  // Carry into bit 3 of the top slice is recoverable from its sum and operand bits.
  assign msb_cin = s4[3] ^ a4[3] ^ b4[3];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            idx     <= '0;
            state   <= ST_ADD;
          end
        end
        ST_ADD: begin
          sum_q[base +: SLICE_W] <= s4;
          carry_q                <= co;
          if (idx == LAST_IDX) begin
            idx    <= '0;
            cout_q <= co;
`ifdef RCA_SEQ_OVF_FLAG_EN
            ovf_q  <= msb_cin ^ co;
`endif
            state  <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_ADD) || (state == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef RCA_SEQ_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// Directed bench for rca_seq_add_ctrl at WIDTH=16; ovf checks follow RCA_SEQ_OVF_FLAG_EN.
module tb_rca_seq_add_ctrl;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef RCA_SEQ_OVF_FLAG_EN
  logic             ovf;
`endif

  int checks   = 0;
  int failures = 0;

  logic [WIDTH:0] exp_q[$];

  rca_seq_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef RCA_SEQ_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present operands for one accept edge, then scramble inputs
  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                      input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    exp_q.push_back({exp_cout, exp_sum});
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    cin      = 1'b1;
  endtask

  // scoreboard: wait (bounded) for out_valid, counting edges from the accept edge as 1
  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    logic [WIDTH:0] e;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (exp_lat > 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    e = exp_q.pop_front();
    check({tag, "_sum"}, 32'(sum), 32'(e[WIDTH-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(e[WIDTH]));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // carry ripple across a nibble boundary, latency and one-cycle out_valid
    send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_in_ready_busy", 32'(in_ready), 32'd0);
    wait_result("t1", 5);
    step();
    check("t1_out_valid_drop", 32'(out_valid), 32'd0);
    check("t1_idle_in_ready", 32'(in_ready), 32'd1);
    check("t1_sum_held_idle", 32'(sum), 32'h0100);

    // full wrap
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    wait_result("t2", 5);
    step();

    // wrap via cin
    send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    wait_result("t3", 5);
    step();

    // consumer back-pressure in DONE
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    wait_result("t4", 5);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_out_valid", 32'(out_valid), 32'd1);
      check("t4_hold_in_ready", 32'(in_ready), 32'd0);
      check("t4_hold_sum", 32'(sum), 32'h5555);
    end
    out_ready = 1'b1;
    step();
    check("t4_release_out_valid", 32'(out_valid), 32'd0);
    check("t4_release_in_ready", 32'(in_ready), 32'd1);

    // a request held while busy is ignored, then accepted once back in IDLE
    send(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0);
    a        = 16'h0001;
    b        = 16'h0001;
    cin      = 1'b0;
    in_valid = 1'b1;
    check("t5_in_ready_busy", 32'(in_ready), 32'd0);
    wait_result("t5", 5);
    check("t5_done_in_ready", 32'(in_ready), 32'd0);
    step();
    check("t5_idle_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back({1'b0, 16'h0002});
    step();
    in_valid = 1'b0;
    wait_result("t5_second", 5);
    step();

    // reset during the second ADD cycle aborts the add
    send(16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0);
    check("t6_sum_cleared", 32'(sum), 32'd0);
    step();
    check("t6_first_nibble", 32'(sum), 32'h0002);
    rst = 1'b1;
    void'(exp_q.pop_back());
    step();
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    check("t6_rst_sum", 32'(sum), 32'd0);
    check("t6_rst_cout", 32'(cout), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    send(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
    wait_result("t6_after", 5);
    step();

`ifdef RCA_SEQ_OVF_FLAG_EN
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    wait_result("t7_pos_ovf", 5);
    check("t7_ovf_set", 32'(ovf), 32'd1);
    step();
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    wait_result("t7_no_ovf", 5);
    check("t7_ovf_clear", 32'(ovf), 32'd0);
    step();
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
